fwd_hazard_scoreboard: RTL and testbench
========================================

# fwd_hazard_scoreboard

Parametrised forwarding and load-use hazard unit for the in-order pipelined core, sitting between ID and EX. It keeps a shift-register scoreboard of in-flight destination writes and a registered copy of the EX-stage source fields. From these it produces youngest-wins bypass selects for every EX source operand and a load-use stall request for the instruction in ID. A saturating counter records how many load-use stalls took effect.

## Interface
Parameters:
- RW, 5: register-address width.
- NUM_SRC, 2: source operands per instruction.
- DEPTH, 3: tracked stages after ID.
  - Entry 0 = EX, entry 1 = MEM, entry 2 = WB, and so on.
  - Must be at least 2.
- LOAD_FWD_MIN, 2: lowest entry index from which a load result can be forwarded. Must be at least 1.
- CNT_W, 16: stall-counter width.
- SEL_W, $clog2(DEPTH): select width per source. Derived; do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rd  in  RW  ID destination register.
- id_we  in  1  ID instruction writes the register file.
- id_is_load  in  1  ID instruction is a load.
- id_rs  in  NUM_SRC*RW  ID source registers; source s occupies bits [s*RW +: RW].
- id_rs_used  in  NUM_SRC  bit s set when source s is actually read.
- freeze  in  1  global pipeline hold (e.g. memory wait).
- flush  in  1  kill the instruction in ID.
- load_use_stall  out  1  hold IF/ID this cycle; a bubble is inserted into EX.
- fwd_sel  out  NUM_SRC*SEL_W  bypass select for each EX source; field s at [s*SEL_W +: SEL_W].
- lu_stall_cnt  out  CNT_W  count of effective load-use stalls.

## Operation
State:
- Entries e[0..DEPTH-1], each holding {v, rd, we, ld}.
- Registers ex_rs[NUM_SRC] and ex_used[NUM_SRC], which belong to the instruction in entry 0.
- The stall counter.

A producer P is a valid entry with v=1, we=1 and rd≠0.

fwd_sel[s] is a combinational function of state only:
- It takes the smallest k in 1..DEPTH-1 such that ex_used[s]=1, e[k] is a producer, and e[k].rd = ex_rs[s].
- If no entry matches, fwd_sel[s] = 0, meaning use the register file.
- Youngest-wins: when MEM and WB both match, MEM is selected.
- No special case is needed for loads at k < LOAD_FWD_MIN. The stall logic guarantees they never match a consumer in EX.

load_use_stall is asserted when all of the following hold:
- id_valid=1 and flush=0.
- For some source s, id_rs_used[s]=1.
- Some producer e[i] has ld=1, i+1 < LOAD_FWD_MIN, and e[i].rd = id_rs[s].

With the default parameters this is the classic single-bubble case: a load in EX.

Update per edge, in priority order:
1. rst: all e[*].v=0, ex_used=0, ex_rs=0, counter=0.
2. freeze=1: all state holds. load_use_stall is still driven but has no effect and is not counted.
3. Otherwise entries shift (e[k] ← e[k-1] for k≥1; e[DEPTH-1] retires). Entry 0 is loaded as follows:
   - If flush=1 or load_use_stall=1, entry 0 becomes a bubble (v=0) and ex_used=0.
   - Otherwise e[0] ← {id_valid, id_rd, id_we, id_is_load}, ex_rs ← id_rs, and ex_used ← id_rs_used & {NUM_SRC{id_valid}}.
4. The counter increments when load_use_stall=1 and freeze=0, and saturates at all-ones.

## Timing
- Reset values: every e[*].v=0, fwd_sel=0, load_use_stall=0, lu_stall_cnt=0. These values apply immediately on rst assertion, without waiting for a clock edge.
- fwd_sel has zero latency from state: it is valid throughout the cycle in which the consumer occupies EX.
- load_use_stall is combinational from the ID inputs and state. Per stalled cycle it inserts exactly one bubble.
- A load issued at edge t reaches entry LOAD_FWD_MIN at edge t+LOAD_FWD_MIN. A dependent instruction is stalled until it can enter EX with the load at index ≥ LOAD_FWD_MIN, i.e. LOAD_FWD_MIN-1 stall cycles.
- flush and load_use_stall in the same cycle: flush wins, load_use_stall=0, and the counter does not increment.
- freeze and flush in the same cycle: freeze wins. Flush is ignored and must be held by the source.
- Reset asserted mid-stall: all state clears. The first instruction issued after reset sees no hazard.
- A producer with rd=0 never forwards and never stalls.

## Test plan
- ALU back-to-back: write x5, then a consumer with rs1=x5 → in the consumer's EX cycle fwd_sel[0]=1 and fwd_sel[1]=0.
- Distance-2 and double-match cases:
  - write x5, NOP, consumer of x5 → fwd_sel[0]=2.
  - write x5, write x5, consumer of x5 → fwd_sel[0]=1 (youngest wins).
- Load-use: lw x7, then a consumer with rs2=x7 → load_use_stall=1 for exactly 1 cycle, lu_stall_cnt=1. Next cycle a bubble is in EX; when the consumer is in EX, fwd_sel[1]=2.
- x0 and unused sources:
  - lw x0, then a consumer of x0 → no stall, fwd_sel=0.
  - lw x7, then a consumer with id_rs=x7 but id_rs_used=0 → no stall.
- Control priority:
  - A load-use condition with flush=1 → load_use_stall=0, the counter is unchanged, and entry 0 becomes a bubble.
  - freeze=1 for 3 cycles during a stall → state and fwd_sel are unchanged, and the counter is unchanged.
  - Parameter sweep with DEPTH=4, LOAD_FWD_MIN=3 → a dependent load stalls 2 cycles, then fwd_sel=3.
- Reset with a stall pending → outputs drop to 0 asynchronously. After release, lu_stall_cnt=0 and no stale forwarding occurs.

Source files
------------

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and load-use hazard unit between ID and EX: a shift-register scoreboard of
// in-flight writes drives youngest-wins bypass selects and the load-use stall request.
module fwd_hazard_scoreboard #(
  parameter int RW           = 5,
  parameter int NUM_SRC      = 2,
  parameter int DEPTH        = 3,
  parameter int LOAD_FWD_MIN = 2,
  parameter int CNT_W        = 16,
  parameter int SEL_W        = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [RW-1:0]            id_rd,
  input  logic                     id_we,
  input  logic                     id_is_load,
  input  logic [NUM_SRC*RW-1:0]    id_rs,
  input  logic [NUM_SRC-1:0]       id_rs_used,
  input  logic                     freeze,
  input  logic                     flush,
  output logic                     load_use_stall,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic [CNT_W-1:0]         lu_stall_cnt
);

  logic [DEPTH-1:0]   e_v;
  logic [DEPTH-1:0]   e_we;
  logic [DEPTH-1:0]   e_ld;
  logic [RW-1:0]      e_rd [DEPTH];
  logic [DEPTH-1:0]   prod;
  logic [RW-1:0]      ex_rs [NUM_SRC];
  logic [NUM_SRC-1:0] ex_used;
  logic [CNT_W-1:0]   cnt_q;
  logic               hazard;
  logic               bubble;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      prod[k] = e_v[k] & e_we[k] & (e_rd[k] != '0);
    end
  end

  // Scan oldest to youngest so the youngest matching producer overwrites the select.
  always_comb begin
    fwd_sel = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (ex_used[s] && prod[k] && (e_rd[k] == ex_rs[s])) begin
          fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(k);
        end
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((i + 1 < LOAD_FWD_MIN) && id_rs_used[s] && prod[i] && e_ld[i] &&
            (e_rd[i] == id_rs[s*RW +: RW])) begin
          hazard = 1'b1;
        end
      end
    end
  end

  assign load_use_stall = id_valid & ~flush & hazard;
  assign bubble         = flush | load_use_stall;
  assign lu_stall_cnt   = cnt_q;

  // Control state: valid bits, EX source tags and the stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_v     <= '0;
      ex_used <= '0;
      cnt_q   <= '0;
      for (int s = 0; s < NUM_SRC; s++) begin
        ex_rs[s] <= '0;
      end
    end else if (!freeze) begin
      e_v <= {e_v[DEPTH-2:0], (~bubble & id_valid)};
      if (bubble) begin
        ex_used <= '0;
      end else begin
        ex_used <= id_rs_used & {NUM_SRC{id_valid}};
        for (int s = 0; s < NUM_SRC; s++) begin
          ex_rs[s] <= id_rs[s*RW +: RW];
        end
      end
      if (load_use_stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Payload fields are qualified by e_v, so they need no reset.
  always_ff @(posedge clk) begin
    if (!freeze) begin
      e_we    <= {e_we[DEPTH-2:0], id_we};
      e_ld    <= {e_ld[DEPTH-2:0], id_is_load};
      e_rd[0] <= id_rd;
      for (int k = 1; k < DEPTH; k++) begin
        e_rd[k] <= e_rd[k-1];
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed table-driven bench for fwd_hazard_scoreboard plus hand-written sequences
// for async reset mid-stall and a DEPTH=4 / LOAD_FWD_MIN=3 instance.
module tb_fwd_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_we, id_is_load, freeze, flush;
  logic [4:0]  id_rd;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic        stall3, stall4;
  logic [3:0]  sel3, sel4;
  logic [15:0] cnt3, cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_scoreboard u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .freeze(freeze), .flush(flush), .load_use_stall(stall3), .fwd_sel(sel3),
    .lu_stall_cnt(cnt3)
  );

  fwd_hazard_scoreboard #(.DEPTH(4), .LOAD_FWD_MIN(3)) u_d4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .freeze(freeze), .flush(flush), .load_use_stall(stall4), .fwd_sel(sel4),
    .lu_stall_cnt(cnt4)
  );

  typedef struct {
    int v, rd, we, ld, rs0, rs1, used, frz, fl;
    int stall, s0, s1, cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input int v, rd, we, ld, rs0, rs1, used, frz, fl,
                     input int stall, s0, s1, cnt);
    vec_t t;
    t = '{v, rd, we, ld, rs0, rs1, used, frz, fl, stall, s0, s1, cnt};
    tbl.push_back(t);
  endtask

  task automatic nop(input int stall, s0, s1, cnt);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, stall, s0, s1, cnt);
  endtask

  task automatic drive(input int v, rd, we, ld, rs0, rs1, used, frz, fl);
    id_valid   = v[0];
    id_rd      = rd[4:0];
    id_we      = we[0];
    id_is_load = ld[0];
    id_rs      = {rs1[4:0], rs0[4:0]};
    id_rs_used = used[1:0];
    freeze     = frz[0];
    flush      = fl[0];
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_stall", int'(stall3), 0);
    chk("reset_sel",   int'(sel3), 0);
    chk("reset_cnt",   int'(cnt3), 0);
    chk("reset_sel_d4", int'(sel4), 0);

    //  v rd we ld rs0 rs1 used frz fl | stall s0 s1 cnt
    row(1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // add x5
    row(1, 8, 1, 0, 5, 6, 3, 0, 0,  0, 0, 0, 0);   // consumer x5, x6
    nop(0, 1, 0, 0);                               // back-to-back: MEM
    row(1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // add x5
    nop(0, 0, 0, 0);
    row(1, 9, 1, 0, 5, 0, 1, 0, 0,  0, 0, 0, 0);   // consumer x5
    nop(0, 2, 0, 0);                               // distance 2: WB
    row(1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // add x5
    row(1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // add x5
    row(1, 9, 1, 0, 5, 0, 1, 0, 0,  0, 0, 0, 0);   // consumer x5
    nop(0, 1, 0, 0);                               // youngest wins
    row(1, 7, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // lw x7
    row(1, 9, 1, 0, 3, 7, 2, 0, 0,  1, 0, 0, 0);   // consumer rs2=x7: stall
    row(1, 9, 1, 0, 3, 7, 2, 0, 0,  0, 0, 0, 1);   // bubble in EX
    nop(0, 0, 2, 1);                               // load forwarded from WB
    row(1, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1);   // lw x0
    row(1, 9, 1, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1);   // consumer x0: no stall
    nop(0, 0, 0, 1);
    row(1, 7, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1);   // lw x7
    row(1, 9, 1, 0, 7, 7, 0, 0, 0,  0, 0, 0, 1);   // x7 named but unused
    nop(0, 0, 0, 1);
    row(1, 7, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1);   // lw x7
    row(1, 9, 1, 0, 0, 7, 2, 0, 1,  0, 0, 0, 1);   // flush beats stall
    row(1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);   // EX must be a bubble
    row(1, 7, 1, 1, 5, 0, 1, 0, 0,  0, 0, 0, 1);   // lw x7 reading x5
    row(1, 9, 1, 0, 0, 7, 2, 1, 0,  1, 1, 0, 1);   // freeze during stall
    row(1, 9, 1, 0, 0, 7, 2, 1, 0,  1, 1, 0, 1);
    row(1, 9, 1, 0, 0, 7, 2, 1, 0,  1, 1, 0, 1);
    row(1, 9, 1, 0, 0, 7, 2, 0, 0,  1, 1, 0, 1);   // freeze released
    row(1, 9, 1, 0, 0, 7, 2, 0, 0,  0, 0, 0, 2);
    nop(0, 0, 2, 2);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].rd, tbl[i].we, tbl[i].ld, tbl[i].rs0, tbl[i].rs1,
            tbl[i].used, tbl[i].frz, tbl[i].fl);
      #1;
      chk($sformatf("row%0d_stall", i), int'(stall3), tbl[i].stall);
      chk($sformatf("row%0d_sel0", i), int'(sel3[1:0]), tbl[i].s0);
      chk($sformatf("row%0d_sel1", i), int'(sel3[3:2]), tbl[i].s1);
      chk($sformatf("row%0d_cnt", i), int'(cnt3), tbl[i].cnt);
      @(negedge clk);
    end

    // Async reset while a stall and a forward are pending.
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 7, 1, 1, 5, 0, 1, 0, 0);
    @(negedge clk);
    drive(1, 9, 1, 0, 0, 7, 2, 0, 0);
    #1;
    chk("pre_rst_stall", int'(stall3), 1);
    chk("pre_rst_sel0",  int'(sel3[1:0]), 1);
    chk("pre_rst_cnt",   int'(cnt3), 2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_stall", int'(stall3), 0);
    chk("async_rst_sel",   int'(sel3), 0);
    chk("async_rst_cnt",   int'(cnt3), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 9, 1, 0, 5, 7, 3, 0, 0);
    #1;
    chk("post_rst_stall", int'(stall3), 0);
    chk("post_rst_cnt",   int'(cnt3), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("post_rst_sel", int'(sel3), 0);
    chk("post_rst_cnt2", int'(cnt3), 0);
    @(negedge clk);

    // DEPTH=4, LOAD_FWD_MIN=3: two stall cycles, then forward from entry 3.
    drive(1, 7, 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 9, 1, 0, 0, 7, 2, 0, 0);
    #1;
    chk("d4_stall_1", int'(stall4), 1);
    chk("d3_stall_1", int'(stall3), 1);
    @(negedge clk);
    #1;
    chk("d4_stall_2", int'(stall4), 1);
    chk("d3_no_stall_2", int'(stall3), 0);
    @(negedge clk);
    #1;
    chk("d4_stall_3", int'(stall4), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("d4_sel1", int'(sel4[3:2]), 3);
    chk("d4_sel0", int'(sel4[1:0]), 0);
    chk("d4_cnt",  int'(cnt4), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
